// File: rtl/rxq_admit_pkg.sv
// rxq_admit shared definitions: word layout, gap word and FSM encoding.
// Imported by the admission stage and its counters.
package rxq_admit_pkg;

    localparam int FRAME_BIT = 8;
    localparam int WORD_W = 9;
    localparam logic [WORD_W-1:0] GAP_WORD = 9'h000;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_PASS,
        ST_DROP,
        ST_TRUNC,
        ST_GAPGEN
    } state_e;

    function automatic logic is_frame(input logic [WORD_W-1:0] w);
        return w[FRAME_BIT];
    endfunction

endpackage

// File: rtl/rxq_admit_sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step only when enabled and not already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rxq_admit.sv
// Frame admission between receive queue and rx-tx queue.
// Forwards whole frames only, truncates oversize ones, regenerates the gap.
module rxq_admit
    import rxq_admit_pkg::*;
#(
    parameter logic [11:0] MAX_FRAME = 12'd1530,
    parameter logic [3:0]  GAP       = 4'h8,
    parameter logic [12:0] DEPTH     = 13'd4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [8:0]  dout,
    input  logic        empty,
    output logic        rd_en,
    output logic [8:0]  din,
    input  logic        full,
    output logic        wr_en,
    input  logic [11:0] data_count,
    output logic [31:0] frame_cnt,
    output logic [31:0] drop_cnt,
    output logic [15:0] trunc_cnt
);

    state_e      state_q, state_d;
    logic [11:0] len_q, len_d;
    logic [3:0]  gap_q, gap_d;
    logic [8:0]  din_q, din_d;
    logic        wr_en_q, wr_en_d;

    logic        stall;
    logic        reads;
    logic        fb;
    logic        admit;
    logic [12:0] free;
    logic [12:0] need;
    logic        frame_inc;
    logic        drop_inc;
    logic        trunc_inc;

    assign free  = DEPTH - {1'b0, data_count};
    assign need  = {1'b0, MAX_FRAME} + {9'b0, GAP};
    assign admit = (free >= need);
    assign fb    = is_frame(dout);
    assign stall = wr_en_q & full;
    assign reads = (state_q != ST_GAPGEN);
    assign rd_en = !empty & reads & !stall & !sys_rst;

    // Next-state, output-stage and statistics decode; hold all while stalled.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        gap_d     = gap_q;
        din_d     = din_q;
        wr_en_d   = wr_en_q;
        frame_inc = 1'b0;
        drop_inc  = 1'b0;
        trunc_inc = 1'b0;
        if (!stall) begin
            wr_en_d = 1'b0;
            unique case (state_q)
                ST_SYNC: begin
                    if (rd_en && !fb) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (rd_en && fb) begin
                        if (admit) begin
                            wr_en_d = 1'b1;
                            din_d   = dout;
                            len_d   = 12'd1;
                            state_d = ST_PASS;
                        end else begin
                            drop_inc = 1'b1;
                            state_d  = ST_DROP;
                        end
                    end
                end
                ST_PASS: begin
                    if (rd_en) begin
                        if (fb) begin
                            if (len_q < MAX_FRAME) begin
                                wr_en_d = 1'b1;
                                din_d   = dout;
                                len_d   = len_q + 12'd1;
                            end else begin
                                trunc_inc = 1'b1;
                                state_d   = ST_TRUNC;
                            end
                        end else begin
                            frame_inc = 1'b1;
                            wr_en_d   = (GAP != 4'd0);
                            din_d     = GAP_WORD;
                            gap_d     = 4'd1;
                            state_d   = (GAP <= 4'd1) ? ST_IDLE : ST_GAPGEN;
                        end
                    end
                end
                ST_DROP: begin
                    if (rd_en && !fb) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TRUNC: begin
                    if (rd_en && !fb) begin
                        frame_inc = 1'b1;
                        wr_en_d   = (GAP != 4'd0);
                        din_d     = GAP_WORD;
                        gap_d     = 4'd1;
                        state_d   = (GAP <= 4'd1) ? ST_IDLE : ST_GAPGEN;
                    end
                end
                ST_GAPGEN: begin
                    wr_en_d = 1'b1;
                    din_d   = GAP_WORD;
                    gap_d   = gap_q + 4'd1;
                    if (gap_q >= (GAP - 4'd1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    // State, length, gap count and registered output stage.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_SYNC;
            len_q   <= 12'd0;
            gap_q   <= 4'd0;
            din_q   <= 9'd0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            din_q   <= din_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign din   = din_q;
    assign wr_en = wr_en_q;

    sat_counter #(.W(32)) u_frame_cnt (
        .clk_i (sys_clk),
        .clr_i (sys_rst),
        .inc_i (frame_inc),
        .cnt_o (frame_cnt)
    );

    sat_counter #(.W(32)) u_drop_cnt (
        .clk_i (sys_clk),
        .clr_i (sys_rst),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt)
    );

    sat_counter #(.W(16)) u_trunc_cnt (
        .clk_i (sys_clk),
        .clr_i (sys_rst),
        .inc_i (trunc_inc),
        .cnt_o (trunc_cnt)
    );

endmodule

// File: tb/tb_rxq_admit.sv
// Self-checking bench for rxq_admit: table of frame scenarios
// plus directed stall, back-to-back and mid-frame reset sequences.
module tb_rxq_admit;

    logic        sys_clk;
    logic        sys_rst;
    logic [8:0]  dout;
    logic        empty;
    logic        rd_en;
    logic [8:0]  din;
    logic        full;
    logic        wr_en;
    logic [11:0] data_count;
    logic [31:0] frame_cnt;
    logic [31:0] drop_cnt;
    logic [15:0] trunc_cnt;

    rxq_admit dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .dout       (dout),
        .empty      (empty),
        .rd_en      (rd_en),
        .din        (din),
        .full       (full),
        .wr_en      (wr_en),
        .data_count (data_count),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt),
        .trunc_cnt  (trunc_cnt)
    );

    typedef struct {
        int len;
        int dc;
        int exp_words;
        int d_frame;
        int d_drop;
        int d_trunc;
    } vec_t;

    vec_t tbl[7];

    logic [8:0] up_q[$];
    logic [8:0] out_q[$];
    logic [8:0] exp_q[$];

    int checks;
    int errors;
    int cyc;
    int lat_pop;
    int lat_wr;
    int lat_din;
    int ef;
    int ed;
    int et;

    logic       m_pop;
    logic       m_acc;
    logic       m_wr;
    logic [8:0] m_din;
    logic [8:0] m_dout;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Upstream FWFT queue and downstream capture model.
    always begin
        @(negedge sys_clk);
        m_pop  = rd_en;
        m_acc  = wr_en && !full;
        m_wr   = wr_en;
        m_din  = din;
        m_dout = dout;
        @(posedge sys_clk);
        #1;
        cyc = cyc + 1;
        if (m_pop && m_dout[8] && lat_pop < 0) lat_pop = cyc;
        if (m_wr && lat_wr < 0) begin
            lat_wr  = cyc;
            lat_din = int'(m_din);
        end
        if (m_pop && up_q.size() > 0) void'(up_q.pop_front());
        if (m_acc) out_q.push_back(m_din);
        empty = (up_q.size() == 0);
        dout  = empty ? 9'h000 : up_q[0];
    end

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input int len, input int seed, input int ew);
        for (int i = 0; i < len; i++) begin
            logic [8:0] w;
            w = {1'b1, 8'(seed + i)};
            up_q.push_back(w);
            if (i < ew) exp_q.push_back(w);
        end
        up_q.push_back(9'h0A5);
        if (ew > 0) begin
            for (int g = 0; g < 8; g++) exp_q.push_back(9'h000);
        end
    endtask

    task automatic wait_done(input string name);
        int idle;
        bit ok;
        idle = 0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (up_q.size() == 0 && !wr_en) idle = idle + 1;
            else idle = 0;
            if (idle >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s timeout got busy expected idle", name);
        end
    endtask

    task automatic check_out(input string name);
        int bad;
        bad = 0;
        check_eq({name, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            if (out_q[i] !== exp_q[i]) bad = bad + 1;
        end
        check_eq({name, "_words_bad"}, bad, 0);
    endtask

    task automatic check_cnts(input string name);
        check_eq({name, "_frame_cnt"}, frame_cnt, ef);
        check_eq({name, "_drop_cnt"}, drop_cnt, ed);
        check_eq({name, "_trunc_cnt"}, trunc_cnt, et);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        lat_pop    = -1;
        lat_wr     = -1;
        lat_din    = -1;
        ef         = 0;
        ed         = 0;
        et         = 0;
        sys_rst    = 1'b1;
        full       = 1'b0;
        data_count = 12'd0;

        tbl[0] = '{72,   0,    72,   1, 0, 0};
        tbl[1] = '{40,   3000, 0,    0, 1, 0};
        tbl[2] = '{5,    0,    5,    1, 0, 0};
        tbl[3] = '{1,    0,    1,    1, 0, 0};
        tbl[4] = '{1600, 0,    1530, 1, 0, 1};
        tbl[5] = '{10,   2558, 10,   1, 0, 0};
        tbl[6] = '{10,   2559, 0,    0, 1, 0};

        repeat (3) tick();
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_din", din, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_cnts("rst");
        sys_rst = 1'b0;

        up_q.push_back(9'h0A5);
        wait_done("sync");
        out_q.delete();

        for (int r = 0; r < 7; r++) begin
            string nm;
            nm = $sformatf("row%0d", r);
            data_count = tbl[r].dc[11:0];
            exp_q.delete();
            out_q.delete();
            if (r == 0) begin
                lat_pop = -1;
                lat_wr  = -1;
            end
            push_frame(tbl[r].len, 16 * r + 3, tbl[r].exp_words);
            wait_done(nm);
            check_out(nm);
            ef = ef + tbl[r].d_frame;
            ed = ed + tbl[r].d_drop;
            et = et + tbl[r].d_trunc;
            check_cnts(nm);
            if (r == 0) begin
                check_eq("latency", lat_wr - lat_pop, 1);
                check_eq("first_din", lat_din, 9'h103);
            end
        end

        data_count = 12'd0;
        exp_q.delete();
        out_q.delete();
        push_frame(20, 200, 20);
        begin
            bit seen;
            logic [8:0] held;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (out_q.size() >= 8) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            check_eq("stall_reach", seen, 1);
            full = 1'b1;
            @(negedge sys_clk);
            held = din;
            for (int i = 0; i < 5; i++) begin
                check_eq($sformatf("stall_rd_en%0d", i), rd_en, 0);
                check_eq($sformatf("stall_wr_en%0d", i), wr_en, 1);
                check_eq($sformatf("stall_din%0d", i), din, held);
                tick();
                @(negedge sys_clk);
            end
            tick();
            full = 1'b0;
        end
        wait_done("stall");
        check_out("stall");
        ef = ef + 1;
        check_cnts("stall");

        exp_q.delete();
        out_q.delete();
        push_frame(6, 90, 6);
        push_frame(9, 120, 9);
        wait_done("b2b");
        check_out("b2b");
        ef = ef + 2;
        check_cnts("b2b");

        exp_q.delete();
        out_q.delete();
        push_frame(100, 7, 0);
        push_frame(20, 60, 20);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (out_q.size() >= 30) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            check_eq("mrst_reach", seen, 1);
        end
        sys_rst = 1'b1;
        tick();
        out_q.delete();
        check_eq("mrst_wr_en", wr_en, 0);
        ef = 0;
        ed = 0;
        et = 0;
        check_cnts("mrst_clr");
        sys_rst = 1'b0;
        wait_done("mrst");
        check_out("mrst");
        ef = 1;
        check_cnts("mrst_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
